// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Opcode/funct constants, PC-select encodings, FSM states and
//               the IF-stage decode helper for the pipeCPU issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [5:0] c_op_arith = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_slt   = 6'h2A;

    localparam logic [1:0] c_pc_seq    = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;
    localparam logic [1:0] c_pc_jr     = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_JR_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic       use_rs;
        logic       use_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       has_dest;
        logic [4:0] dest;
        logic       is_jump;
        logic       is_branch;
        logic       is_bne;
        logic       is_jr;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t d;
        d      = '0;
        d.rs   = instr[25:21];
        d.rt   = instr[20:16];
        case (instr[31:26])
            c_op_arith: begin
                case (instr[5:0])
                    c_fn_add, c_fn_sub, c_fn_slt: begin
                        d.use_rs   = 1'b1;
                        d.use_rt   = 1'b1;
                        d.has_dest = 1'b1;
                        d.dest     = instr[15:11];
                    end
                    c_fn_jr: begin
                        d.use_rs = 1'b1;
                        d.is_jr  = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_op_lw, c_op_addi, c_op_xori: begin
                d.use_rs   = 1'b1;
                d.has_dest = 1'b1;
                d.dest     = instr[20:16];
            end
            c_op_sw: begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            c_op_beq, c_op_bne: begin
                d.use_rs    = 1'b1;
                d.use_rt    = 1'b1;
                d.is_branch = 1'b1;
                d.is_bne    = (instr[31:26] == c_op_bne);
            end
            c_op_j: d.is_jump = 1'b1;
            c_op_jal: begin
                d.is_jump  = 1'b1;
                d.has_dest = 1'b1;
                d.dest     = 5'd31;
            end
            default: ;
        endcase
        // $0 writes are discarded by the regfile, so never track them
        if (d.dest == 5'd0) d.has_dest = 1'b0;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Shift register of in-flight destinations with a two-source
//               RAW compare.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int SB_DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [4:0] load_dest,
    input  logic       src_a_valid,
    input  logic [4:0] src_a,
    input  logic       src_b_valid,
    input  logic [4:0] src_b,
    output logic       raw_hit
);

    logic [SB_DEPTH-1:0] r_valid;
    logic [4:0]          r_dest [SB_DEPTH];
    logic                w_hit;

    // Shifts every cycle regardless of PC hold: a stalled slot is a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < SB_DEPTH; i++) r_dest[i] <= 5'd0;
        end else begin
            r_valid[0] <= load_valid;
            r_dest[0]  <= load_dest;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_dest[i]  <= r_dest[i-1];
            end
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (r_valid[i]) begin
                if (src_a_valid && (src_a != 5'd0) && (src_a == r_dest[i])) w_hit = 1'b1;
                if (src_b_valid && (src_b != 5'd0) && (src_b == r_dest[i])) w_hit = 1'b1;
            end
        end
    end

    assign raw_hit = w_hit;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Issue/stall sequencer for the 5-stage pipeCPU: RAW interlock,
//               branch/JR redirect sequencing and stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SB_DEPTH = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_IF,
    input  logic             alu_zero,
    output logic             insert_nop,
    output logic             pc_hold,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    decode_t          w_dec;
    state_t           r_state, w_state_nxt;
    logic             r_br_cnt, w_br_cnt_nxt;
    logic             r_is_bne, w_is_bne_nxt;
    logic             w_raw_hit;
    logic             w_run_issue;
    logic             w_sb_load;
    logic [CNT_W-1:0] r_stall_cycles;

    assign w_dec     = decode_instr(instr_IF);
    assign w_sb_load = ~insert_nop & w_dec.has_dest;

    hazard_scoreboard #(
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (w_sb_load),
        .load_dest   (w_dec.dest),
        .src_a_valid (w_dec.use_rs),
        .src_a       (w_dec.rs),
        .src_b_valid (w_dec.use_rt),
        .src_b       (w_dec.rt),
        .raw_hit     (w_raw_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_br_cnt <= 1'b0;
            r_is_bne <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_br_cnt <= w_br_cnt_nxt;
            r_is_bne <= w_is_bne_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_br_cnt_nxt = r_br_cnt;
        w_is_bne_nxt = r_is_bne;
        insert_nop   = 1'b1;
        pc_hold      = 1'b1;
        pc_sel       = c_pc_seq;
        w_run_issue  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: w_run_issue = 1'b1;
                ST_BR_WAIT: begin
                    if (r_br_cnt) begin
                        w_br_cnt_nxt = 1'b0;
                    end else if (alu_zero ^ r_is_bne) begin
                        pc_hold     = 1'b0;
                        pc_sel      = c_pc_branch;
                        w_state_nxt = ST_RUN;
                    end else begin
                        // Fall-through word gets full RUN treatment so a
                        // control-flow word there is still sequenced
                        w_state_nxt = ST_RUN;
                        w_run_issue = 1'b1;
                    end
                end
                ST_JR_WAIT: begin
                    pc_hold     = 1'b0;
                    pc_sel      = c_pc_jr;
                    w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase

            if (w_run_issue && !w_raw_hit) begin
                insert_nop = 1'b0;
                pc_hold    = 1'b0;
                if (w_dec.is_jump) begin
                    pc_sel = c_pc_jump;
                end else if (w_dec.is_branch) begin
                    w_state_nxt  = ST_BR_WAIT;
                    w_br_cnt_nxt = 1'b1;
                    w_is_bne_nxt = w_dec.is_bne;
                end else if (w_dec.is_jr) begin
                    w_state_nxt = ST_JR_WAIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (insert_nop && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign busy         = ~reset & (r_state != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_IF;
    logic        alu_zero;

    logic        insert_nop, pc_hold, busy;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cycles;

    logic        insert_nop2, pc_hold2, busy2;
    logic [1:0]  pc_sel2;
    logic [1:0]  stall_cycles2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.SB_DEPTH(3), .CNT_W(16)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .instr_IF     (instr_IF),
        .alu_zero     (alu_zero),
        .insert_nop   (insert_nop),
        .pc_hold      (pc_hold),
        .pc_sel       (pc_sel),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    pipe_hazard_ctrl #(.SB_DEPTH(3), .CNT_W(2)) u_dut_sat (
        .clk          (clk),
        .reset        (reset),
        .instr_IF     (instr_IF),
        .alu_zero     (alu_zero),
        .insert_nop   (insert_nop2),
        .pc_hold      (pc_hold2),
        .pc_sel       (pc_sel2),
        .busy         (busy2),
        .stall_cycles (stall_cycles2)
    );

    function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic apply_reset();
        reset    = 1'b1;
        instr_IF = 32'h0;
        alu_zero = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Control vector below is {insert_nop, pc_hold, pc_sel[1:0], busy}
    task automatic test_reset();
        reset    = 1'b1;
        instr_IF = r_type(6'h20, 5'd2, 5'd3, 5'd1);
        alu_zero = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({insert_nop, pc_hold, pc_sel, busy} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", {insert_nop, pc_hold, pc_sel, busy}, 5'b11000);
        end
        n_checks++;
        if (stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_raw();
        logic [31:0] seq [6];
        logic [4:0]  exp [6];
        apply_reset();
        seq = '{r_type(6'h20, 5'd2, 5'd3, 5'd1), r_type(6'h20, 5'd1, 5'd1, 5'd4),
                r_type(6'h20, 5'd1, 5'd1, 5'd4), r_type(6'h20, 5'd1, 5'd1, 5'd4),
                r_type(6'h20, 5'd1, 5'd1, 5'd4), 32'h0};
        exp = '{5'b00000, 5'b11000, 5'b11000, 5'b11000, 5'b00000, 5'b00000};
        for (int i = 0; i < 6; i++) begin
            instr_IF = seq[i];
            @(negedge clk);
            n_checks++;
            if ({insert_nop, pc_hold, pc_sel, busy} !== exp[i]) begin
                n_fail++;
                $display("FAIL raw_c%0d: got %b expected %b", i, {insert_nop, pc_hold, pc_sel, busy}, exp[i]);
            end
            next_cycle();
        end
        n_checks++;
        if (stall_cycles !== 16'd3) begin
            n_fail++;
            $display("FAIL raw_stall: got %0d expected 3", stall_cycles);
        end
    endtask

    task automatic test_beq_taken();
        logic [31:0] seq [4];
        logic        az  [4];
        logic [4:0]  exp [4];
        apply_reset();
        seq = '{i_type(6'h04, 5'd0, 5'd0, 16'd4), i_type(6'h08, 5'd0, 5'd2, 16'd5),
                i_type(6'h08, 5'd0, 5'd2, 16'd5), i_type(6'h08, 5'd0, 5'd3, 16'd1)};
        az  = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{5'b00000, 5'b11001, 5'b10011, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            instr_IF = seq[i];
            alu_zero = az[i];
            @(negedge clk);
            n_checks++;
            if ({insert_nop, pc_hold, pc_sel, busy} !== exp[i]) begin
                n_fail++;
                $display("FAIL beq_c%0d: got %b expected %b", i, {insert_nop, pc_hold, pc_sel, busy}, exp[i]);
            end
            next_cycle();
        end
        n_checks++;
        if (stall_cycles !== 16'd2) begin
            n_fail++;
            $display("FAIL beq_stall: got %0d expected 2", stall_cycles);
        end
    endtask

    task automatic test_bne_not_taken();
        logic [31:0] seq [5];
        logic        az  [5];
        logic [4:0]  exp [5];
        apply_reset();
        seq = '{i_type(6'h05, 5'd0, 5'd0, 16'd4), i_type(6'h08, 5'd0, 5'd2, 16'd5),
                i_type(6'h08, 5'd0, 5'd2, 16'd5), i_type(6'h08, 5'd0, 5'd3, 16'd1),
                r_type(6'h20, 5'd2, 5'd2, 5'd4)};
        az  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp = '{5'b00000, 5'b11001, 5'b00001, 5'b00000, 5'b11000};
        for (int i = 0; i < 5; i++) begin
            instr_IF = seq[i];
            alu_zero = az[i];
            @(negedge clk);
            n_checks++;
            if ({insert_nop, pc_hold, pc_sel, busy} !== exp[i]) begin
                n_fail++;
                $display("FAIL bne_c%0d: got %b expected %b", i, {insert_nop, pc_hold, pc_sel, busy}, exp[i]);
            end
            next_cycle();
        end
        n_checks++;
        if (stall_cycles !== 16'd2) begin
            n_fail++;
            $display("FAIL bne_stall: got %0d expected 2", stall_cycles);
        end
    endtask

    task automatic test_jal_jr();
        logic [31:0] seq [7];
        logic [4:0]  exp [7];
        apply_reset();
        seq = '{{6'h03, 26'h40}, r_type(6'h08, 5'd31, 5'd0, 5'd0),
                r_type(6'h08, 5'd31, 5'd0, 5'd0), r_type(6'h08, 5'd31, 5'd0, 5'd0),
                r_type(6'h08, 5'd31, 5'd0, 5'd0), 32'h0, 32'h0};
        exp = '{5'b00100, 5'b11000, 5'b11000, 5'b11000, 5'b00000, 5'b10111, 5'b00000};
        for (int i = 0; i < 7; i++) begin
            instr_IF = seq[i];
            @(negedge clk);
            n_checks++;
            if ({insert_nop, pc_hold, pc_sel, busy} !== exp[i]) begin
                n_fail++;
                $display("FAIL jal_jr_c%0d: got %b expected %b", i, {insert_nop, pc_hold, pc_sel, busy}, exp[i]);
            end
            next_cycle();
        end
        n_checks++;
        if (stall_cycles !== 16'd4) begin
            n_fail++;
            $display("FAIL jal_jr_stall: got %0d expected 4", stall_cycles);
        end
    endtask

    task automatic test_reset_in_branch();
        apply_reset();
        instr_IF = r_type(6'h20, 5'd2, 5'd3, 5'd1);
        next_cycle();
        instr_IF = i_type(6'h04, 5'd0, 5'd0, 16'd4);
        next_cycle();
        instr_IF = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({insert_nop, pc_hold, pc_sel, busy} !== 5'b11001) begin
            n_fail++;
            $display("FAIL rstbr_wait: got %b expected %b", {insert_nop, pc_hold, pc_sel, busy}, 5'b11001);
        end
        reset    = 1'b1;
        alu_zero = 1'b1;
        #1;
        n_checks++;
        if ({insert_nop, pc_hold, pc_sel, busy} !== 5'b11000) begin
            n_fail++;
            $display("FAIL rstbr_during: got %b expected %b", {insert_nop, pc_hold, pc_sel, busy}, 5'b11000);
        end
        next_cycle();
        reset = 1'b0;
        n_checks++;
        if (stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL rstbr_stall: got %0d expected 0", stall_cycles);
        end
        // $1 would still sit in the oldest slot had the scoreboard survived
        instr_IF = r_type(6'h20, 5'd1, 5'd1, 5'd4);
        @(negedge clk);
        n_checks++;
        if ({insert_nop, pc_hold, pc_sel, busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rstbr_after: got %b expected %b", {insert_nop, pc_hold, pc_sel, busy}, 5'b00000);
        end
        next_cycle();
        instr_IF = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({insert_nop, pc_hold, pc_sel, busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rstbr_noredir: got %b expected %b", {insert_nop, pc_hold, pc_sel, busy}, 5'b00000);
        end
        next_cycle();
        alu_zero = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] seq [10];
        logic [4:0]  exp [10];
        apply_reset();
        seq = '{r_type(6'h20, 5'd2, 5'd3, 5'd1), r_type(6'h20, 5'd1, 5'd1, 5'd4),
                r_type(6'h20, 5'd1, 5'd1, 5'd4), r_type(6'h20, 5'd1, 5'd1, 5'd4),
                r_type(6'h20, 5'd1, 5'd1, 5'd4), r_type(6'h20, 5'd2, 5'd3, 5'd9),
                r_type(6'h20, 5'd4, 5'd4, 5'd5), r_type(6'h20, 5'd4, 5'd4, 5'd5),
                r_type(6'h20, 5'd4, 5'd4, 5'd5), 32'h0};
        exp = '{5'b00000, 5'b11000, 5'b11000, 5'b11000, 5'b00000,
                5'b00000, 5'b11000, 5'b11000, 5'b00000, 5'b00000};
        for (int i = 0; i < 10; i++) begin
            instr_IF = seq[i];
            @(negedge clk);
            n_checks++;
            if ({insert_nop, pc_hold, pc_sel, busy} !== exp[i]) begin
                n_fail++;
                $display("FAIL sat_c%0d: got %b expected %b", i, {insert_nop, pc_hold, pc_sel, busy}, exp[i]);
            end
            if (i == 5) begin
                n_checks++;
                if (stall_cycles2 !== 2'd3) begin
                    n_fail++;
                    $display("FAIL sat_mid: got %0d expected 3", stall_cycles2);
                end
            end
            next_cycle();
        end
        n_checks++;
        if (stall_cycles !== 16'd5) begin
            n_fail++;
            $display("FAIL sat_wide: got %0d expected 5", stall_cycles);
        end
        n_checks++;
        if (stall_cycles2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_narrow: got %0d expected 3", stall_cycles2);
        end
    endtask

    initial begin
        reset    = 1'b1;
        instr_IF = 32'h0;
        alu_zero = 1'b0;
        test_reset();
        test_raw();
        test_beq_taken();
        test_bne_not_taken();
        test_jal_jr();
        test_reset_in_branch();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
